// File: rtl/rambus_arb_pkg.sv
// Shared types and field widths for the rambus Wishbone arbiter.
package rambus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int WDOG_WIDTH = 8;
    localparam int SEL_WIDTH  = 4;
    localparam int DAT_WIDTH  = 32;

endpackage

// File: rtl/rambus_arbiter_rr.sv
// Combinational round-robin picker: grants the first requester after the
// one-hot 'last' owner, wrapping around.
module rr_arbiter
    import rambus_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    // One extra bit so the rotate amount can equal N when the last owner is N-1.
    localparam int IW = $clog2(N) + 1;

    logic [IW-1:0]  shamt;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] gnt_dbl;

    always_comb begin
        shamt = '0;
        for (int i = 0; i < N; i++) begin
            if (last[i]) begin
                shamt = IW'(i + 1);
            end
        end
    end

    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> shamt);

    always_comb begin
        rot_gnt = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                rot_gnt    = '0;
                rot_gnt[j] = 1'b1;
            end
        end
    end

    // Rotate the winner back and fold the wrapped half onto the low half.
    assign gnt_dbl = {{N{1'b0}}, rot_gnt} << shamt;
    assign gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

endmodule

// File: rtl/rambus_arbiter.sv
// Round-robin arbiter sharing the OpenRAM rambus Wishbone port between
// several masters, with grant held per CYC and a no-ack watchdog.
module rambus_arbiter
    import rambus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [4*NUM_MASTERS-1:0]          m_sel_i,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0]         m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [31:0]                       m_dat_o,
    output logic                              rambus_wb_clk_o,
    output logic                              rambus_wb_rst_o,
    output logic                              rambus_wb_cyc_o,
    output logic                              rambus_wb_stb_o,
    output logic                              rambus_wb_we_o,
    output logic [3:0]                        rambus_wb_sel_o,
    output logic [ADDR_WIDTH-1:0]             rambus_wb_adr_o,
    output logic [31:0]                       rambus_wb_dat_o,
    input  logic                              rambus_wb_ack_i,
    input  logic [31:0]                       rambus_wb_dat_i,
    output logic [NUM_MASTERS-1:0]            arb_grant_o,
    output logic                              arb_timeout_o
);

    localparam logic [NUM_MASTERS-1:0] LAST_RESET = {1'b1, {(NUM_MASTERS-1){1'b0}}};
    localparam logic [WDOG_WIDTH-1:0]  WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_t                 state_reg;
    logic [NUM_MASTERS-1:0]     grant_reg;
    logic [NUM_MASTERS-1:0]     last_grant_reg;
    logic [WDOG_WIDTH-1:0]      wdog_reg;

    logic [NUM_MASTERS-1:0]     req;
    logic [NUM_MASTERS-1:0]     pick;

    logic [SEL_WIDTH-1:0]       sel_arr [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]      adr_arr [NUM_MASTERS];
    logic [DAT_WIDTH-1:0]       dat_arr [NUM_MASTERS];

    logic                       mux_cyc;
    logic                       mux_stb;
    logic                       mux_we;
    logic [SEL_WIDTH-1:0]       mux_sel;
    logic [ADDR_WIDTH-1:0]      mux_adr;
    logic [DAT_WIDTH-1:0]       mux_dat;
    logic                       bus_busy;
    logic                       bus_abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
            assign sel_arr[gi] = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
            assign adr_arr[gi] = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dat_arr[gi] = m_dat_i[gi*DAT_WIDTH +: DAT_WIDTH];
        end
    endgenerate

    assign req = m_cyc_i & m_stb_i;

    rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr (
        .req  (req),
        .last (last_grant_reg),
        .gnt  (pick)
    );

    // Grant is one-hot (or zero), so a plain select loop is an AND-OR mux.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_sel = '0;
        mux_adr = '0;
        mux_dat = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_reg[k]) begin
                mux_cyc = m_cyc_i[k];
                mux_stb = m_stb_i[k];
                mux_we  = m_we_i[k];
                mux_sel = sel_arr[k];
                mux_adr = adr_arr[k];
                mux_dat = dat_arr[k];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_RESET;
            wdog_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wdog_reg <= '0;
                    if (|req) begin
                        grant_reg <= pick;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mux_cyc) begin
                        last_grant_reg <= grant_reg;
                        grant_reg      <= '0;
                        wdog_reg       <= '0;
                        state_reg      <= IDLE;
                    end else if (rambus_wb_ack_i) begin
                        // An ack on the limit cycle still completes the beat.
                        wdog_reg <= '0;
                    end else if (mux_stb) begin
                        if (wdog_reg == WDOG_LIMIT) begin
                            state_reg <= ABORT;
                        end else begin
                            wdog_reg <= wdog_reg + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    last_grant_reg <= grant_reg;
                    grant_reg      <= '0;
                    wdog_reg       <= '0;
                    state_reg      <= IDLE;
                end
                default: begin
                    grant_reg <= '0;
                    wdog_reg  <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus_busy  = (state_reg == BUSY);
    assign bus_abort = (state_reg == ABORT);

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_ni;
    assign rambus_wb_cyc_o = bus_busy & mux_cyc;
    assign rambus_wb_stb_o = bus_busy & mux_stb;
    assign rambus_wb_we_o  = bus_busy & mux_we;
    assign rambus_wb_sel_o = bus_busy ? mux_sel : '0;
    assign rambus_wb_adr_o = bus_busy ? mux_adr : '0;
    assign rambus_wb_dat_o = bus_busy ? mux_dat : '0;

    assign m_ack_o       = bus_busy ? (grant_reg & {NUM_MASTERS{rambus_wb_ack_i}}) : '0;
    assign m_dat_o       = bus_busy ? rambus_wb_dat_i : '0;
    assign m_err_o       = bus_abort ? grant_reg : '0;
    assign arb_timeout_o = bus_abort;
    assign arb_grant_o   = grant_reg;

endmodule
